component_skid_buffer: RTL and testbench



---
 rtl/component_skid_buffer.sv | 120 ++++++++++++
 tb/tb_component_skid_buffer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/component_skid_buffer.sv
// Two-entry valid/ready skid buffer with registered ready, data and valid outputs.
// Optional stall counter output is enabled by defining COMPONENT_SKID_BUFFER_STALL_CNT_EN.
module component_skid_buffer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef COMPONENT_SKID_BUFFER_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  // FULL is the only state in which the skid register holds a live beat.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic               in_ready_q, in_ready_d;
  logic               in_fire;
  logic               out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d    = BUSY;
            out_data_d = in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            out_data_d = in_data;
          end else if (in_fire) begin
            state_d     = FULL;
            skid_data_d = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a drain can move the state.
          if (out_fire) begin
            state_d    = BUSY;
            out_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef COMPONENT_SKID_BUFFER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      stall_cnt_d = 16'h0000;
    end else if (in_valid && !in_ready_q && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_component_skid_buffer.sv
// Bench for component_skid_buffer: directed scenarios then random traffic against a queue model.
// Stall counter checks are active when COMPONENT_SKID_BUFFER_STALL_CNT_EN is defined.
module tb_component_skid_buffer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef COMPONENT_SKID_BUFFER_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: the buffer is a FIFO of at most two beats.
  logic [WIDTH-1:0] m_q[$];
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [15:0]      m_stall;

  component_skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef COMPONENT_SKID_BUFFER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
    check({tag, ".out_data"},  32'(out_data),  32'(m_data));
    check({tag, ".in_ready"},  32'(in_ready),  32'(m_ready));
`ifdef COMPONENT_SKID_BUFFER_STALL_CNT_EN
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
`endif
    $display("%-8s iv=%0b id=%02h or=%0b fl=%0b -> ov=%0b od=%02h ir=%0b",
             tag, in_valid, in_data, out_ready, flush, out_valid, out_data, in_ready);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ready = 1'b0;
    m_data  = '0;
    m_stall = 16'h0000;
  endtask

  // Drive inputs (called just after a falling edge), advance one clock, check at the next falling edge.
  task automatic cycle(input string tag, input logic iv, input logic [WIDTH-1:0] id,
                       input logic ordy, input logic fl);
    logic pre_ready;
    logic fire_in;
    logic fire_out;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    pre_ready = m_ready;
    fire_in   = iv && pre_ready;
    fire_out  = (m_q.size() > 0) && ordy;
    if (fl) m_stall = 16'h0000;
    else if (iv && !pre_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (fl) begin
      m_q.delete();
    end else begin
      if (fire_out) void'(m_q.pop_front());
      if (fire_in) m_q.push_back(id);
    end
    m_ready = (m_q.size() < 2);
    if (m_q.size() > 0) m_data = m_q[0];
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    cycle("release", 1'b0, 8'h00, 1'b0, 1'b0);
    check("release.in_ready_one", 32'(in_ready), 32'd1);

    // Streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      cycle("stream", 1'b1, WIDTH'(i), 1'b1, 1'b0);
      check("stream.data", 32'(out_data), 32'(i));
    end
    cycle("idle", 1'b0, 8'h00, 1'b1, 1'b0);

    // Stall then drain
    cycle("stallA", 1'b1, 8'h0A, 1'b0, 1'b0);
    cycle("stallB", 1'b1, 8'h0B, 1'b0, 1'b0);
    check("stall.full_ready", 32'(in_ready), 32'd0);
    check("stall.hold_A", 32'(out_data), 32'h0A);
    cycle("drain1", 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain1.B", 32'(out_data), 32'h0B);
    cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous fire in BUSY
    cycle("sim5", 1'b1, 8'h05, 1'b0, 1'b0);
    cycle("sim6", 1'b1, 8'h06, 1'b1, 1'b0);
    check("sim.data6", 32'(out_data), 32'h06);
    check("sim.ready", 32'(in_ready), 32'd1);
    cycle("simdrn", 1'b0, 8'h00, 1'b1, 1'b0);

    // Flush while FULL drops the pending beat
    cycle("fill7", 1'b1, 8'h07, 1'b0, 1'b0);
    cycle("fill8", 1'b1, 8'h08, 1'b0, 1'b0);
    cycle("flush", 1'b1, 8'h09, 1'b0, 1'b1);
    check("flush.valid", 32'(out_valid), 32'd0);
    check("flush.ready", 32'(in_ready), 32'd1);
    cycle("postfl", 1'b0, 8'h00, 1'b1, 1'b0);

    // Stall counter: three stalled cycles while FULL, then flush
    cycle("cntA", 1'b1, 8'h11, 1'b0, 1'b0);
    cycle("cntB", 1'b1, 8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("cntS", 1'b1, 8'h13, 1'b0, 1'b0);
`ifdef COMPONENT_SKID_BUFFER_STALL_CNT_EN
    check("cnt.three", 32'(stall_cnt), 32'd3);
`endif
    cycle("cntFl", 1'b0, 8'h00, 1'b0, 1'b1);
`ifdef COMPONENT_SKID_BUFFER_STALL_CNT_EN
    check("cnt.clear", 32'(stall_cnt), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), WIDTH'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset in the middle of a cycle while FULL
    cycle("rfillA", 1'b1, 8'hC1, 1'b0, 1'b0);
    cycle("rfillB", 1'b1, 8'hC2, 1'b0, 1'b0);
    check("rfill.full", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1 check_all("arst_rel");
    cycle("arst_up", 1'b0, 8'h00, 1'b0, 1'b0);
    check("arst.ready_one", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
